// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding and the default
// memory geometry used by the processor top.
package prog_loader_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FILL  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    // States in which a new load request is honoured.
    function automatic logic accepts_start(input state_t st);
        return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERROR);
    endfunction

endpackage

// File: rtl/prog_loader_counter.sv
// Loadable up-counter used as the memory address pointer; it saturates at LAST
// so it can never wrap, and flags when it sits on LAST.
module prog_loader_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LAST  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             out_of_range
);

    assign out_of_range = (count == WIDTH'(LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc && !out_of_range) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams program words into block RAM from address 0, optionally zero-fills
// the remainder, and holds the CPU off until memory is fully programmed.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter bit          CLEAR_REST = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int unsigned RAM_DEPTH   = 2 ** ADDR_WIDTH;
    localparam int unsigned COUNT_WIDTH = ADDR_WIDTH + 1;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  ptr_last;
    logic                  ptr_load;
    logic                  ptr_inc;
    logic                  handshake;

    prog_loader_counter #(
        .WIDTH (ADDR_WIDTH),
        .LAST  (RAM_DEPTH - 1)
    ) u_ptr (
        .clk          (clk),
        .reset        (reset),
        .load         (ptr_load),
        .load_value   ('0),
        .inc          (ptr_inc),
        .count        (ptr),
        .out_of_range (ptr_last)
    );

    // Pointer control follows the same decisions the state register makes.
    always_comb begin
        handshake = s_valid & s_ready;
        ptr_load  = 1'b0;
        ptr_inc   = 1'b0;
        if (accepts_start(state)) begin
            ptr_load = start;
        end else if (state == ST_LOAD) begin
            ptr_inc = handshake;
        end else if (state == ST_FILL) begin
            ptr_inc = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            s_ready    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            mem_wen <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state      <= ST_LOAD;
                        s_ready    <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        word_count <= '0;
                    end else begin
                        s_ready  <= 1'b0;
                        cpu_hold <= 1'b0;
                        done     <= (state == ST_DONE);
                        error    <= (state == ST_ERROR);
                    end
                end
                ST_LOAD: begin
                    if (handshake) begin
                        mem_wen    <= 1'b1;
                        mem_addr   <= ptr;
                        mem_wdata  <= s_data;
                        word_count <= word_count + COUNT_WIDTH'(1);
                        if (s_last) begin
                            s_ready <= 1'b0;
                            state   <= (CLEAR_REST && !ptr_last) ? ST_FILL : ST_FLUSH;
                        end else if (ptr_last) begin
                            // Memory is full and more words are coming.
                            s_ready <= 1'b0;
                            state   <= ST_ERROR;
                        end
                    end
                end
                ST_FILL: begin
                    mem_wen   <= 1'b1;
                    mem_addr  <= ptr;
                    mem_wdata <= '0;
                    if (ptr_last) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: one instance without and one with zero-fill,
// both driven by the same stream and checked against a write-log model.
module tb_prog_loader;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 8;
    localparam int          DEPTH = 256;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;

    logic          s_ready0, mem_wen0, cpu_hold0, done0, error0;
    logic [AW-1:0] mem_addr0;
    logic [DW-1:0] mem_wdata0;
    logic [AW:0]   word_count0;
    logic          s_ready1, mem_wen1, cpu_hold1, done1, error1;
    logic [AW-1:0] mem_addr1;
    logic [DW-1:0] mem_wdata1;
    logic [AW:0]   word_count1;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int done_at0, done_at1, err_at0, err_at1;

    wr_t           log0[$], log1[$], exp0[$], exp1[$];
    int            hs_cyc[$];
    logic [DW-1:0] prog[$];
    bit            vpat[$];

    always #5 clk = ~clk;

    prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_REST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready0), .mem_wen(mem_wen0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .cpu_hold(cpu_hold0), .done(done0), .error(error0),
        .word_count(word_count0)
    );

    prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_REST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready1), .mem_wen(mem_wen1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .cpu_hold(cpu_hold1), .done(done1), .error(error1),
        .word_count(word_count1)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // Advance one clock, sample just after the edge and log any memory writes.
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        if (mem_wen0 === 1'b1) log0.push_back('{cycle, int'(mem_addr0), int'(mem_wdata0)});
        if (mem_wen1 === 1'b1) log1.push_back('{cycle, int'(mem_addr1), int'(mem_wdata1)});
        if (done0 === 1'b1 && done_at0 < 0) done_at0 = cycle;
        if (done1 === 1'b1 && done_at1 < 0) done_at1 = cycle;
        if (error0 === 1'b1 && err_at0 < 0) err_at0 = cycle;
        if (error1 === 1'b1 && err_at1 < 0) err_at1 = cycle;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_ready0"}, s_ready0, 0);
        check({pfx, "_wen0"},   mem_wen0, 0);
        check({pfx, "_addr0"},  mem_addr0, 0);
        check({pfx, "_wdata0"}, mem_wdata0, 0);
        check({pfx, "_hold0"},  cpu_hold0, 0);
        check({pfx, "_done0"},  done0, 0);
        check({pfx, "_error0"}, error0, 0);
        check({pfx, "_wc0"},    word_count0, 0);
        check({pfx, "_ready1"}, s_ready1, 0);
        check({pfx, "_wen1"},   mem_wen1, 0);
        check({pfx, "_addr1"},  mem_addr1, 0);
        check({pfx, "_wdata1"}, mem_wdata1, 0);
        check({pfx, "_hold1"},  cpu_hold1, 0);
        check({pfx, "_done1"},  done1, 0);
        check({pfx, "_error1"}, error1, 0);
        check({pfx, "_wc1"},    word_count1, 0);
    endtask

    task automatic compare_log(input string pfx, input wr_t got[$], input wr_t exp[$]);
        int n;
        check({pfx, "_nwrites"}, got.size(), exp.size());
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_wcyc[%0d]", pfx, i), got[i].cyc, exp[i].cyc);
            check($sformatf("%s_waddr[%0d]", pfx, i), got[i].addr, exp[i].addr);
            check($sformatf("%s_wdata[%0d]", pfx, i), got[i].data, exp[i].data);
        end
    endtask

    task automatic rand_prog(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back(DW'($urandom));
    endtask

    // One complete load: start, stream prog with random gaps, then check writes,
    // status and latency. abort_after>0 resets mid-stream; pulse_start pokes start
    // right after the last handshake.
    task automatic run_load(input int n, input bit last_flag, input int gap_pct,
                            input int abort_after, input bit pulse_start);
        int  idx;
        int  budget;
        int  w;
        int  m;
        int  t_last;
        int  fill;
        bit  sv;
        bit  rdy;
        bit  ok;

        log0.delete(); log1.delete(); exp0.delete(); exp1.delete(); hs_cyc.delete();
        done_at0 = -1; done_at1 = -1; err_at0 = -1; err_at1 = -1;

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ready0", s_ready0, 1);
        check("start_ready1", s_ready1, 1);
        check("start_hold0", cpu_hold0, 1);
        check("start_hold1", cpu_hold1, 1);
        check("start_wc0", word_count0, 0);
        check("start_wc1", word_count1, 0);
        check("start_done1", done1, 0);
        check("start_error1", error1, 0);

        idx = 0;
        budget = 0;
        while (idx < n && budget < 4000) begin
            if (abort_after > 0 && idx == abort_after) break;
            sv = (vpat.size() > 0) ? vpat.pop_front() : ($urandom_range(99) >= gap_pct);
            s_valid = sv;
            s_data  = sv ? prog[idx] : DW'($urandom);
            s_last  = sv ? (last_flag && idx == n - 1) : 1'($urandom_range(1));
            rdy = s_ready0;
            check("stream_ready0", s_ready0, 1);
            check("stream_ready1", s_ready1, 1);
            tick();
            budget++;
            if (sv && rdy) begin
                hs_cyc.push_back(cycle);
                idx++;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        vpat.delete();

        m = idx;
        for (int i = 0; i < m; i++) begin
            exp0.push_back('{hs_cyc[i], i, int'(prog[i])});
            exp1.push_back('{hs_cyc[i], i, int'(prog[i])});
        end

        if (abort_after > 0) begin
            check("abort_words", m, abort_after);
            reset = 1'b1;
            tick();
            check_zero("abort");
            reset = 1'b0;
            repeat (3) tick();
            check_zero("abort_idle");
            compare_log("abort_log0", log0, exp0);
            compare_log("abort_log1", log1, exp1);
            return;
        end

        check("stream_words", m, n);
        t_last = (m > 0) ? hs_cyc[m - 1] : cycle;
        check("post_ready0", s_ready0, 0);
        check("post_ready1", s_ready1, 0);

        if (pulse_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end

        w = 0;
        while (!((done_at0 >= 0 || err_at0 >= 0) && (done_at1 >= 0 || err_at1 >= 0)) && w < 600) begin
            tick();
            w++;
        end
        check("finish_in_budget", (w < 600) ? 1 : 0, 1);
        repeat (4) tick();

        ok   = last_flag && (m <= DEPTH);
        fill = (ok && m < DEPTH) ? DEPTH - m : 0;
        for (int k = 1; k <= fill; k++) exp1.push_back('{t_last + k, m - 1 + k, 0});

        if (ok) begin
            check("done_lat0", done_at0, t_last + 2);
            check("done_lat1", done_at1, t_last + fill + 2);
            check("done0", done0, 1);
            check("done1", done1, 1);
            check("error0", error0, 0);
            check("error1", error1, 0);
        end else begin
            check("err_lat0", err_at0, t_last + 1);
            check("err_lat1", err_at1, t_last + 1);
            check("error0", error0, 1);
            check("error1", error1, 1);
            check("done0", done0, 0);
            check("done1", done1, 0);
        end
        check("end_hold0", cpu_hold0, 0);
        check("end_hold1", cpu_hold1, 0);
        check("end_ready0", s_ready0, 0);
        check("end_ready1", s_ready1, 0);
        check("end_wc0", word_count0, m);
        check("end_wc1", word_count1, m);
        compare_log("log0", log0, exp0);
        compare_log("log1", log1, exp1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        done_at0 = -1; done_at1 = -1; err_at0 = -1; err_at1 = -1;
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b0;
        tick();
        check_zero("idle");

        prog.delete(); prog.push_back(16'h1111); prog.push_back(16'h2222); prog.push_back(16'h3333);
        run_load(3, 1'b1, 0, 0, 1'b0);

        prog.delete(); prog.push_back(16'hA5A5); prog.push_back(16'h5A5A);
        run_load(2, 1'b1, 0, 0, 1'b0);

        rand_prog(DEPTH);
        run_load(DEPTH, 1'b1, 30, 0, 1'b0);

        rand_prog(DEPTH);
        run_load(DEPTH, 1'b0, 20, 0, 1'b0);

        prog.delete(); prog.push_back(16'd7); prog.push_back(16'd8); prog.push_back(16'd9);
        vpat.delete();
        vpat.push_back(1'b1); vpat.push_back(1'b0); vpat.push_back(1'b0);
        vpat.push_back(1'b1); vpat.push_back(1'b1);
        run_load(3, 1'b1, 0, 0, 1'b0);

        rand_prog(12);
        run_load(12, 1'b1, 10, 5, 1'b0);

        rand_prog(10);
        run_load(10, 1'b1, 25, 0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(60, 1));
            rand_prog(n);
            run_load(n, 1'b1, int'($urandom_range(50, 0)), 0, 1'b0);
        end

        rand_prog(DEPTH - 1);
        run_load(DEPTH - 1, 1'b1, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer-side companion to the processor's instruction/data memory.
- Accepts a stream of program words from a host or debug interface over a valid/ready handshake.
- Writes the words into block_ram starting at address 0, optionally zero-fills the rest of memory, then signals completion.
- Holds the CPU controller off (cpu_hold) while loading, so memory is fully programmed before a start.

Parameters:
- DATA_WIDTH, 16, memory word width; matches the processor data bus.
- ADDR_WIDTH, 8, memory address width.
- RAM_DEPTH, 2**ADDR_WIDTH, number of memory words.
- CLEAR_REST, 1, 1 = zero-fill addresses after the last loaded word up to RAM_DEPTH-1; 0 = leave them untouched.

Ports:
- clk  in  1  system clock (clk100MHz domain).
- reset  in  1  synchronous, active-high reset.
- start  in  1  level-sampled request to begin a load; honoured only in IDLE, DONE or ERROR.
- s_valid  in  1  stream word valid.
- s_data  in  DATA_WIDTH  stream word.
- s_last  in  1  marks the final word of the program; qualified by s_valid.
- s_ready  out  1  loader can accept a word this cycle.
- mem_wen  out  1  memory write enable (registered).
- mem_addr  out  ADDR_WIDTH  memory address (registered).
- mem_wdata  out  DATA_WIDTH  memory write data (registered).
- cpu_hold  out  1  high while a load or fill is in progress.
- done  out  1  level; load completed successfully.
- error  out  1  level, sticky; program longer than RAM_DEPTH.
- word_count  out  ADDR_WIDTH+1  number of stream words accepted in the current or last load.

Behaviour:
- Reset (synchronous, priority over everything):
  - state = IDLE.
  - All outputs 0: s_ready, mem_wen, mem_addr, mem_wdata, cpu_hold, done, error, word_count.
  - A reset mid-load aborts the load immediately; no further writes occur.
- States: IDLE, LOAD, FILL, FLUSH, DONE, ERROR.
- IDLE / DONE / ERROR:
  - s_ready=0, mem_wen=0.
  - start=1 -> LOAD; clears the internal address pointer, word_count, done and error.
  - start in LOAD, FILL or FLUSH is ignored.
- LOAD:
  - s_ready=1, cpu_hold=1.
  - Handshake = s_valid & s_ready in cycle N. Then in cycle N+1: mem_wen=1, mem_addr=ptr, mem_wdata=s_data from cycle N. In the same step ptr increments and word_count increments.
  - mem_wen=0 in any cycle that follows a non-handshake cycle.
  - Handshake with s_last=1:
    - If CLEAR_REST=1 and ptr<RAM_DEPTH-1 -> FILL.
    - Otherwise -> FLUSH.
  - Handshake at ptr==RAM_DEPTH-1 with s_last=0: the word is still written, then -> ERROR (the memory is full; the next word has no destination). s_ready drops in cycle N+1.
  - Exactly RAM_DEPTH words with s_last on the final word is legal -> FLUSH; word_count = RAM_DEPTH.
- FILL:
  - s_ready=0.
  - Writes 0 to addresses ptr..RAM_DEPTH-1 on consecutive cycles, mem_wen=1 every cycle.
  - After the RAM_DEPTH-1 write is issued -> FLUSH.
  - word_count is not changed.
- FLUSH:
  - One cycle; it lets the final registered write commit.
  - mem_wen=0, cpu_hold=1 -> DONE.
- DONE:
  - done=1, cpu_hold=0.
  - Latency: last stream handshake in cycle N with CLEAR_REST=0 -> final write in N+1, FLUSH in N+2, done=1 first in cycle N+3.
- ERROR:
  - error=1, done=0, cpu_hold=0.
  - Memory contents are undefined beyond the written words.
- ptr is ADDR_WIDTH bits and never wraps. Overflow is caught before wrap.
- word_count saturates logically at RAM_DEPTH; the extra bit covers RAM_DEPTH itself.
- The first handshake is possible in the cycle after start is sampled, because s_ready rises as LOAD is entered.

Decomposition:
- Shared package: state encoding constants (IDLE=0, LOAD=1, FILL=2, FLUSH=3, DONE=4, ERROR=5) and the default width constants DATA_WIDTH=16 and ADDR_WIDTH=8, shared with the processor top.
- One sub-module is natural: the existing counter (load/increment/out_of_range) serves as the address pointer. No other sub-modules.

Test Plan:
- CLEAR_REST=0, start, stream 0x1111, 0x2222, 0x3333 (last on third) -> writes addr0..2 with those values in three consecutive cycles; done=1 three cycles after the last handshake; word_count=3; cpu_hold low in DONE.
- CLEAR_REST=1, stream 2 words (0xA5A5, 0x5A5A) -> addr0..1 loaded, addr2..255 written 0 (254 zero writes); done=1; word_count=2.
- Stream 256 words, last on 256th -> addr255 written, done=1, error=0, word_count=256. Repeat with s_last=0 on the 256th -> error=1, s_ready=0, no write beyond addr255, no wrap to addr0.
- Backpressure/gaps: s_valid toggling 1,0,0,1,1 with data 7,x,x,8,9 -> mem_wen pattern 1,0,0,1,1 shifted one cycle; addresses 0,1,2 contiguous.
- reset asserted while in LOAD after 5 words -> next cycle all outputs 0, state IDLE. A subsequent start reloads from addr0.
- start pulsed during FILL -> ignored; fill completes normally and done=1; a start in DONE begins a new load with word_count cleared.
